// File: rtl/uart_result_streamer.sv
// Streams output memory words 0..len-1 to a UART transmitter, one byte per frame,
// paced by tx_done, optionally followed by a mod-2**DATA_BITS checksum byte.
module uart_result_streamer #(
  parameter int unsigned ADDR_BITS     = 9,
  parameter int unsigned DATA_BITS     = 8,
  parameter int unsigned LEN_BITS      = 16,
  parameter bit          SEND_CHECKSUM = 1'b1
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 start,
  input  logic                 abort,
  input  logic [LEN_BITS-1:0]  len,
  output logic [ADDR_BITS-1:0] mem_addr,
  output logic                 mem_rd_en,
  input  logic [DATA_BITS-1:0] mem_data,
  output logic                 tx_dv,
  output logic [DATA_BITS-1:0] tx_byte,
  input  logic                 tx_active,
  input  logic                 tx_done,
  output logic                 busy,
  output logic                 done,
  output logic [DATA_BITS-1:0] checksum
);

  // One extra bit so a full memory (2**ADDR_BITS words) is representable.
  localparam int unsigned CNT_BITS = ADDR_BITS + 1;
  localparam logic [CNT_BITS-1:0] MAX_LEN = {1'b1, {ADDR_BITS{1'b0}}};

  typedef enum logic [2:0] {
    S_IDLE,
    S_FETCH,
    S_LATCH,
    S_SEND,
    S_WAIT_TX,
    S_CSUM,
    S_WAIT_CS,
    S_FIN
  } state_t;

  state_t              state_q;
  logic [CNT_BITS-1:0] len_q;
  logic [CNT_BITS-1:0] count_q;
  logic [CNT_BITS-1:0] count_inc;
  logic [CNT_BITS-1:0] len_clamped;

  always_comb begin
    len_clamped = MAX_LEN;
    if (32'(len) < 32'(MAX_LEN)) begin
      len_clamped = CNT_BITS'(len);
    end
  end

  assign count_inc = count_q + CNT_BITS'(1);

  // mem_addr/mem_rd_en are registered on entry to FETCH so the registered RAM
  // returns data during LATCH.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= S_IDLE;
      len_q     <= '0;
      count_q   <= '0;
      mem_addr  <= '0;
      mem_rd_en <= 1'b0;
      tx_dv     <= 1'b0;
      tx_byte   <= '0;
      busy      <= 1'b0;
      done      <= 1'b0;
      checksum  <= '0;
    end else begin
      tx_dv     <= 1'b0;
      done      <= 1'b0;
      mem_rd_en <= 1'b0;
      if (abort) begin
        state_q <= S_IDLE;
        busy    <= 1'b0;
      end else begin
        unique case (state_q)
          S_IDLE: begin
            if (start) begin
              len_q    <= len_clamped;
              count_q  <= '0;
              checksum <= '0;
              busy     <= 1'b1;
              if (len_clamped != '0) begin
                state_q   <= S_FETCH;
                mem_addr  <= '0;
                mem_rd_en <= 1'b1;
              end else if (SEND_CHECKSUM) begin
                state_q <= S_CSUM;
              end else begin
                state_q <= S_FIN;
              end
            end
          end
          S_FETCH: state_q <= S_LATCH;
          S_LATCH: begin
            tx_byte  <= mem_data;
            checksum <= checksum + mem_data;
            state_q  <= S_SEND;
          end
          S_SEND: begin
            if (!tx_active) begin
              tx_dv   <= 1'b1;
              state_q <= S_WAIT_TX;
            end
          end
          S_WAIT_TX: begin
            if (tx_done) begin
              count_q <= count_inc;
              if (count_inc < len_q) begin
                state_q   <= S_FETCH;
                mem_addr  <= count_inc[ADDR_BITS-1:0];
                mem_rd_en <= 1'b1;
              end else if (SEND_CHECKSUM) begin
                state_q <= S_CSUM;
              end else begin
                state_q <= S_FIN;
              end
            end
          end
          S_CSUM: begin
            tx_byte <= checksum;
            if (!tx_active) begin
              tx_dv   <= 1'b1;
              state_q <= S_WAIT_CS;
            end
          end
          S_WAIT_CS: begin
            if (tx_done) begin
              state_q <= S_FIN;
            end
          end
          S_FIN: begin
            done    <= 1'b1;
            busy    <= 1'b0;
            state_q <= S_IDLE;
          end
          default: state_q <= S_IDLE;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_uart_result_streamer.sv
// Directed bench for uart_result_streamer with a registered-RAM model and a simple UART model.
module tb_uart_result_streamer;

  localparam int FRAME = 4;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       start = 1'b0;
  logic       abort = 1'b0;
  logic       start_nc = 1'b0;
  logic       hold_active = 1'b0;
  logic [15:0] len = '0;
  logic [8:0] mem_addr, mem_addr_nc;
  logic       mem_rd_en, mem_rd_en_nc;
  logic [7:0] mem_data = '0;
  logic       tx_dv, tx_dv_nc;
  logic [7:0] tx_byte, tx_byte_nc;
  logic       tx_active, tx_done;
  logic       busy, busy_nc, done, done_nc;
  logic [7:0] checksum, checksum_nc;
  logic       tie0 = 1'b0;

  logic [7:0] mem [512];
  logic [7:0] sent [$];
  int tests = 0;
  int fails = 0;
  int done_cnt = 0;
  int overlap = 0;
  int nc_dv = 0;
  int rd_cnt = 0;
  int first_addr = 0;
  int last_addr = 0;
  int wrap_seen = 0;
  logic u_busy = 1'b0;
  int u_cnt = 0;

  always #5 clk = ~clk;

  uart_result_streamer #(.ADDR_BITS(9), .DATA_BITS(8), .LEN_BITS(16), .SEND_CHECKSUM(1'b1)) u_dut (
    .clk(clk), .rst(rst), .start(start), .abort(abort), .len(len),
    .mem_addr(mem_addr), .mem_rd_en(mem_rd_en), .mem_data(mem_data),
    .tx_dv(tx_dv), .tx_byte(tx_byte), .tx_active(tx_active), .tx_done(tx_done),
    .busy(busy), .done(done), .checksum(checksum));

  uart_result_streamer #(.ADDR_BITS(9), .DATA_BITS(8), .LEN_BITS(16), .SEND_CHECKSUM(1'b0)) u_dut_nc (
    .clk(clk), .rst(rst), .start(start_nc), .abort(tie0), .len(len),
    .mem_addr(mem_addr_nc), .mem_rd_en(mem_rd_en_nc), .mem_data(mem_data),
    .tx_dv(tx_dv_nc), .tx_byte(tx_byte_nc), .tx_active(tie0), .tx_done(tie0),
    .busy(busy_nc), .done(done_nc), .checksum(checksum_nc));

  always @(posedge clk) begin
    if (mem_rd_en) begin
      mem_data <= mem[mem_addr];
      if (rd_cnt == 0) first_addr = int'(mem_addr);
      if (rd_cnt != 0 && int'(mem_addr) <= last_addr) wrap_seen = 1;
      last_addr = int'(mem_addr);
      rd_cnt++;
    end
    if (done) done_cnt++;
    if (tx_dv_nc) nc_dv++;
  end

  assign tx_active = u_busy | hold_active;

  always @(posedge clk or posedge rst) begin
    if (rst) begin
      u_busy  <= 1'b0;
      u_cnt   <= 0;
      tx_done <= 1'b0;
    end else begin
      tx_done <= 1'b0;
      if (tx_dv) begin
        if (tx_active) overlap++;
        sent.push_back(tx_byte);
        u_busy <= 1'b1;
        u_cnt  <= FRAME;
      end else if (u_busy) begin
        if (u_cnt == 0) begin
          u_busy  <= 1'b0;
          tx_done <= 1'b1;
        end else begin
          u_cnt <= u_cnt - 1;
        end
      end
    end
  end

  task automatic pulse_start(input logic [15:0] l);
    @(negedge clk); len = l; start = 1'b1;
    @(negedge clk); start = 1'b0;
  endtask

  task automatic wait_done(input string name, input int budget);
    int d0 = done_cnt;
    int n = 0;
    while (done_cnt == d0 && n < budget) begin
      @(negedge clk); n++;
    end
    tests++;
    if (done_cnt == d0) begin fails++; $display("FAIL %s_timeout: no done within %0d cycles", name, budget); end
  endtask

  task automatic test_reset();
    tests++; if (busy !== 1'b0) begin fails++; $display("FAIL reset_busy: got %b want 0", busy); end
    tests++; if (mem_rd_en !== 1'b0 || tx_dv !== 1'b0 || done !== 1'b0) begin
      fails++; $display("FAIL reset_ctrl: rd_en=%b tx_dv=%b done=%b want 000", mem_rd_en, tx_dv, done); end
    tests++; if (mem_addr !== 9'd0 || tx_byte !== 8'h00 || checksum !== 8'h00) begin
      fails++; $display("FAIL reset_data: addr=%h byte=%h csum=%h want 0", mem_addr, tx_byte, checksum); end
  endtask

  task automatic test_basic();
    logic [7:0] exp [5];
    exp[0] = 8'h10; exp[1] = 8'h20; exp[2] = 8'h30; exp[3] = 8'hF0; exp[4] = 8'h50;
    sent.delete();
    pulse_start(16'd4);
    tests++; if (mem_rd_en !== 1'b1 || mem_addr !== 9'd0 || busy !== 1'b1) begin
      fails++; $display("FAIL basic_fetch: rd_en=%b addr=%h busy=%b want 1,0,1", mem_rd_en, mem_addr, busy); end
    @(negedge clk);
    tests++; if (mem_rd_en !== 1'b0 || tx_dv !== 1'b0) begin
      fails++; $display("FAIL basic_latch: rd_en=%b tx_dv=%b want 0,0", mem_rd_en, tx_dv); end
    @(negedge clk);
    tests++; if (tx_dv !== 1'b0) begin fails++; $display("FAIL basic_early_dv: got %b want 0", tx_dv); end
    @(negedge clk);
    tests++; if (tx_dv !== 1'b1 || tx_byte !== 8'h10) begin
      fails++; $display("FAIL basic_first_dv: dv=%b byte=%h want 1,10", tx_dv, tx_byte); end
    wait_done("basic", 200);
    repeat (3) @(negedge clk);
    tests++; if (sent.size() != 5) begin fails++; $display("FAIL basic_count: got %0d bytes want 5", sent.size()); end
    for (int i = 0; i < 5 && i < sent.size(); i++) begin
      tests++; if (sent[i] !== exp[i]) begin fails++; $display("FAIL basic_byte%0d: got %h want %h", i, sent[i], exp[i]); end
    end
    tests++; if (done_cnt != 1) begin fails++; $display("FAIL basic_done: got %0d pulses want 1", done_cnt); end
    tests++; if (checksum !== 8'h50 || busy !== 1'b0) begin
      fails++; $display("FAIL basic_end: csum=%h busy=%b want 50,0", checksum, busy); end
  endtask

  task automatic test_len0();
    int d0;
    sent.delete();
    pulse_start(16'd0);
    wait_done("len0", 100);
    repeat (3) @(negedge clk);
    tests++; if (sent.size() != 1 || (sent.size() == 1 && sent[0] !== 8'h00)) begin
      fails++; $display("FAIL len0_csum: got %0d bytes (first %h) want 1 byte 00", sent.size(), sent.size() ? sent[0] : 8'hxx); end
    @(negedge clk); len = 16'd0; start_nc = 1'b1;
    @(negedge clk); start_nc = 1'b0;
    tests++; if (done_nc !== 1'b0 || busy_nc !== 1'b1) begin
      fails++; $display("FAIL len0_nc_early: done=%b busy=%b want 0,1", done_nc, busy_nc); end
    @(negedge clk);
    tests++; if (done_nc !== 1'b1) begin fails++; $display("FAIL len0_nc_done: got %b want 1", done_nc); end
    @(negedge clk);
    tests++; if (done_nc !== 1'b0 || busy_nc !== 1'b0 || nc_dv != 0) begin
      fails++; $display("FAIL len0_nc_end: done=%b busy=%b dv_count=%0d want 0,0,0", done_nc, busy_nc, nc_dv); end
    d0 = done_cnt;
  endtask

  task automatic test_active_hold();
    int dv_seen = 0;
    sent.delete(); overlap = 0;
    hold_active = 1'b1;
    pulse_start(16'd4);
    repeat (20) begin @(negedge clk); if (tx_dv) dv_seen++; end
    tests++; if (dv_seen != 0) begin fails++; $display("FAIL hold_dv: got %0d pulses while active want 0", dv_seen); end
    hold_active = 1'b0;
    wait_done("hold", 200);
    repeat (3) @(negedge clk);
    tests++; if (sent.size() != 5 || overlap != 0) begin
      fails++; $display("FAIL hold_count: bytes=%0d overlaps=%0d want 5,0", sent.size(), overlap); end
    tests++; if (sent.size() >= 5 && (sent[0] !== 8'h10 || sent[3] !== 8'hF0 || sent[4] !== 8'h50)) begin
      fails++; $display("FAIL hold_bytes: got %h %h %h want 10 F0 50", sent[0], sent[3], sent[4]); end
  endtask

  task automatic test_restart_ignored();
    int d0 = done_cnt;
    sent.delete();
    pulse_start(16'd3);
    repeat (5) @(negedge clk);
    pulse_start(16'd8);
    repeat (7) @(negedge clk);
    pulse_start(16'd8);
    wait_done("restart", 200);
    repeat (3) @(negedge clk);
    tests++; if (sent.size() != 4) begin fails++; $display("FAIL restart_count: got %0d bytes want 4", sent.size()); end
    tests++; if (sent.size() == 4 && (sent[2] !== 8'h30 || sent[3] !== 8'h60)) begin
      fails++; $display("FAIL restart_bytes: got %h %h want 30 60", sent[2], sent[3]); end
    tests++; if (done_cnt != d0 + 1) begin fails++; $display("FAIL restart_done: got %0d pulses want 1", done_cnt - d0); end
  endtask

  task automatic test_abort();
    int dv_seen = 0;
    int n = 0;
    int d0 = done_cnt;
    sent.delete();
    pulse_start(16'd8);
    while (dv_seen < 2 && n < 200) begin
      @(negedge clk); n++;
      if (tx_dv) dv_seen++;
    end
    tests++; if (dv_seen != 2) begin fails++; $display("FAIL abort_reach: saw %0d tx_dv want 2", dv_seen); end
    abort = 1'b1;
    @(negedge clk); abort = 1'b0;
    tests++; if (busy !== 1'b0 || tx_dv !== 1'b0) begin
      fails++; $display("FAIL abort_idle: busy=%b tx_dv=%b want 0,0", busy, tx_dv); end
    repeat (30) @(negedge clk);
    tests++; if (sent.size() != 2 || done_cnt != d0) begin
      fails++; $display("FAIL abort_quiet: bytes=%0d done=%0d want 2,0", sent.size(), done_cnt - d0); end
    tests++; if (checksum !== 8'h30) begin fails++; $display("FAIL abort_csum_hold: got %h want 30", checksum); end
    @(negedge clk); len = 16'd2; start = 1'b1; abort = 1'b1;
    @(negedge clk); start = 1'b0; abort = 1'b0;
    tests++; if (busy !== 1'b0 || mem_rd_en !== 1'b0) begin
      fails++; $display("FAIL abort_start_same: busy=%b rd_en=%b want 0,0", busy, mem_rd_en); end
    sent.delete(); rd_cnt = 0;
    pulse_start(16'd2);
    wait_done("abort_restart", 200);
    repeat (3) @(negedge clk);
    tests++; if (first_addr != 0 || sent.size() != 3) begin
      fails++; $display("FAIL abort_restart: first_addr=%0d bytes=%0d want 0,3", first_addr, sent.size()); end
    tests++; if (sent.size() == 3 && (sent[0] !== 8'h10 || sent[1] !== 8'h20 || sent[2] !== 8'h30)) begin
      fails++; $display("FAIL abort_restart_bytes: got %h %h %h want 10 20 30", sent[0], sent[1], sent[2]); end
  endtask

  task automatic test_clamp_and_reset();
    logic [7:0] exp_sum = 8'h00;
    int bad = 0;
    int d0;
    for (int i = 0; i < 512; i++) exp_sum = exp_sum + mem[i];
    sent.delete(); rd_cnt = 0; wrap_seen = 0;
    pulse_start(16'd600);
    wait_done("clamp", 8000);
    repeat (3) @(negedge clk);
    tests++; if (sent.size() != 513) begin fails++; $display("FAIL clamp_count: got %0d bytes want 513", sent.size()); end
    for (int i = 0; i < 512 && i < sent.size(); i++) if (sent[i] !== mem[i]) bad++;
    tests++; if (bad != 0) begin fails++; $display("FAIL clamp_payload: got %0d wrong bytes want 0", bad); end
    tests++; if (sent.size() == 513 && sent[512] !== exp_sum) begin
      fails++; $display("FAIL clamp_csum_byte: got %h want %h", sent[512], exp_sum); end
    tests++; if (rd_cnt != 512 || last_addr != 511 || wrap_seen != 0) begin
      fails++; $display("FAIL clamp_addr: reads=%0d last=%0d wrap=%0d want 512,511,0", rd_cnt, last_addr, wrap_seen); end
    tests++; if (checksum !== exp_sum) begin fails++; $display("FAIL clamp_csum_out: got %h want %h", checksum, exp_sum); end
    d0 = done_cnt;
    pulse_start(16'd600);
    repeat (50) @(negedge clk);
    #2 rst = 1'b1;
    #1;
    tests++; if (busy !== 1'b0 || mem_rd_en !== 1'b0 || tx_dv !== 1'b0 || done !== 1'b0) begin
      fails++; $display("FAIL rst_mid_ctrl: busy=%b rd_en=%b dv=%b done=%b want 0000", busy, mem_rd_en, tx_dv, done); end
    tests++; if (mem_addr !== 9'd0 || tx_byte !== 8'h00 || checksum !== 8'h00) begin
      fails++; $display("FAIL rst_mid_data: addr=%h byte=%h csum=%h want 0", mem_addr, tx_byte, checksum); end
    @(negedge clk); rst = 1'b0;
    repeat (20) @(negedge clk);
    tests++; if (done_cnt != d0 || busy !== 1'b0) begin
      fails++; $display("FAIL rst_mid_after: done=%0d busy=%b want 0,0", done_cnt - d0, busy); end
  endtask

  initial begin
    mem[0] = 8'h10; mem[1] = 8'h20; mem[2] = 8'h30; mem[3] = 8'hF0;
    for (int i = 4; i < 512; i++) mem[i] = 8'(i * 7 + 3);
    repeat (3) @(negedge clk);
    test_reset();
    rst = 1'b0;
    @(negedge clk);
    test_reset();
    test_basic();
    test_len0();
    test_active_hold();
    test_restart_ignored();
    test_abort();
    test_clamp_and_reset();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
